// File: rtl/rom_arbiter_if.sv
// Bundle of the two requester ports and the shared ROM port seen by rom_arbiter.
// The arbiter uses the slave modport; the surrounding core (or bench) uses master.
interface rom_arbiter_if #(
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 24,
    parameter int GB_ADDR_W  = 18,
    parameter int NES_ADDR_W = 17
) ();
    logic                  en;

    logic                  req_gb;
    logic [GB_ADDR_W-1:0]  addr_gb;
    logic                  gnt_gb;
    logic                  rvalid_gb;
    logic [DATA_W-1:0]     rdata_gb;

    logic                  req_nes;
    logic [NES_ADDR_W-1:0] addr_nes;
    logic                  gnt_nes;
    logic                  rvalid_nes;
    logic [DATA_W-1:0]     rdata_nes;

    logic [ADDR_W-1:0]     rom_addr;
    logic [DATA_W-1:0]     rom_data;

    modport slave (
        input  en,
        input  req_gb, addr_gb,
        output gnt_gb, rvalid_gb, rdata_gb,
        input  req_nes, addr_nes,
        output gnt_nes, rvalid_nes, rdata_nes,
        output rom_addr,
        input  rom_data
    );

    modport master (
        output en,
        output req_gb, addr_gb,
        input  gnt_gb, rvalid_gb, rdata_gb,
        output req_nes, addr_nes,
        input  gnt_nes, rvalid_nes, rdata_nes,
        input  rom_addr,
        output rom_data
    );
endinterface

// File: rtl/rom_arbiter.sv
// Round-robin sharing of one synchronous-read ROM port between the GB and NES
// cartridge fetch paths, with a tag pipeline routing each returned word in grant order.
module rom_arbiter #(
    parameter int                ADDR_W     = 18,
    parameter int                DATA_W     = 24,
    parameter int                GB_ADDR_W  = 18,
    parameter int                NES_ADDR_W = 17,
    parameter logic [ADDR_W-1:0] NES_BASE   = 18'h20000,
    parameter int                ROM_LAT    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    rom_arbiter_if.slave  bus
);

    typedef struct packed {
        logic vld;
        logic id;     // 0 = GB, 1 = NES
    } tag_t;

    logic              ptr_q, ptr_d;
    logic              gnt_gb_q, gnt_gb_d;
    logic              gnt_nes_q, gnt_nes_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              rvalid_gb_q, rvalid_gb_d;
    logic              rvalid_nes_q, rvalid_nes_d;
    logic [DATA_W-1:0] rdata_gb_q, rdata_gb_d;
    logic [DATA_W-1:0] rdata_nes_q, rdata_nes_d;
    tag_t [ROM_LAT:0]  tag_q, tag_d;

    logic              elig_gb;
    logic              elig_nes;
    logic [ADDR_W-1:0] gb_addr_ext;
    logic [ADDR_W-1:0] nes_addr_ext;
    tag_t              ret_tag;

    // A displayed grant masks its own request, so a held req cannot be granted twice.
    assign elig_gb  = bus.req_gb  & ~gnt_gb_q  & bus.en;
    assign elig_nes = bus.req_nes & ~gnt_nes_q & bus.en;

    assign gb_addr_ext  = ADDR_W'(bus.addr_gb);
    assign nes_addr_ext = ADDR_W'(bus.addr_nes) + NES_BASE;

    always_comb begin
        gnt_gb_d  = 1'b0;
        gnt_nes_d = 1'b0;
        if (elig_gb && elig_nes) begin
            if (ptr_q) begin
                gnt_nes_d = 1'b1;
            end else begin
                gnt_gb_d = 1'b1;
            end
        end else if (elig_gb) begin
            gnt_gb_d = 1'b1;
        end else if (elig_nes) begin
            gnt_nes_d = 1'b1;
        end
    end

    always_comb begin
        ptr_d      = ptr_q;
        rom_addr_d = rom_addr_q;
        if (gnt_gb_d) begin
            ptr_d      = 1'b1;
            rom_addr_d = gb_addr_ext;
        end else if (gnt_nes_d) begin
            ptr_d      = 1'b0;
            rom_addr_d = nes_addr_ext;
        end
    end

    // Stage 0 is aligned with rom_addr; stage ROM_LAT is aligned with valid rom_data.
    always_comb begin
        tag_d      = tag_q;
        tag_d[0]   = '{vld: gnt_gb_d | gnt_nes_d, id: gnt_nes_d};
        for (int k = 1; k <= ROM_LAT; k++) begin
            tag_d[k] = tag_q[k-1];
        end
    end

    assign ret_tag = tag_q[ROM_LAT];

    always_comb begin
        rvalid_gb_d  = ret_tag.vld & ~ret_tag.id;
        rvalid_nes_d = ret_tag.vld &  ret_tag.id;
        rdata_gb_d   = rdata_gb_q;
        rdata_nes_d  = rdata_nes_q;
        if (rvalid_gb_d) begin
            rdata_gb_d = bus.rom_data;
        end
        if (rvalid_nes_d) begin
            rdata_nes_d = bus.rom_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q        <= 1'b0;
            gnt_gb_q     <= 1'b0;
            gnt_nes_q    <= 1'b0;
            rom_addr_q   <= '0;
            tag_q        <= '0;
            rvalid_gb_q  <= 1'b0;
            rvalid_nes_q <= 1'b0;
            rdata_gb_q   <= '0;
            rdata_nes_q  <= '0;
        end else begin
            ptr_q        <= ptr_d;
            gnt_gb_q     <= gnt_gb_d;
            gnt_nes_q    <= gnt_nes_d;
            rom_addr_q   <= rom_addr_d;
            tag_q        <= tag_d;
            rvalid_gb_q  <= rvalid_gb_d;
            rvalid_nes_q <= rvalid_nes_d;
            rdata_gb_q   <= rdata_gb_d;
            rdata_nes_q  <= rdata_nes_d;
        end
    end

    assign bus.gnt_gb     = gnt_gb_q;
    assign bus.gnt_nes    = gnt_nes_q;
    assign bus.rom_addr   = rom_addr_q;
    assign bus.rvalid_gb  = rvalid_gb_q;
    assign bus.rvalid_nes = rvalid_nes_q;
    assign bus.rdata_gb   = rdata_gb_q;
    assign bus.rdata_nes  = rdata_nes_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: a vector table for single-port traffic, then
// hand-written sequences for contention, en gating, mid-flight reset and address wrap.
module tb_rom_arbiter;
    localparam int ADDR_W     = 18;
    localparam int DATA_W     = 24;
    localparam int GB_ADDR_W  = 18;
    localparam int NES_ADDR_W = 17;
    localparam int ROM_LAT    = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rom_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .GB_ADDR_W(GB_ADDR_W),
                     .NES_ADDR_W(NES_ADDR_W)) bus ();
    rom_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .GB_ADDR_W(GB_ADDR_W),
                     .NES_ADDR_W(NES_ADDR_W)) bus_w ();

    rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .GB_ADDR_W(GB_ADDR_W),
                  .NES_ADDR_W(NES_ADDR_W), .NES_BASE(18'h20000), .ROM_LAT(ROM_LAT))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .GB_ADDR_W(GB_ADDR_W),
                  .NES_ADDR_W(NES_ADDR_W), .NES_BASE(18'h30000), .ROM_LAT(ROM_LAT))
        dut_w (.clk(clk), .rst_n(rst_n), .bus(bus_w));

    function automatic logic [23:0] rom_f(input logic [17:0] a);
        return {6'h0, a} ^ 24'hA5A5A5;
    endfunction

    // ROM model: word appears ROM_LAT cycles after its address
    logic [23:0] rom_pipe [ROM_LAT];
    always @(posedge clk) begin
        rom_pipe[0] <= rom_f(bus.rom_addr);
        for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign bus.rom_data   = rom_pipe[ROM_LAT-1];
    assign bus_w.rom_data = '0;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic en, input logic rg, input logic [17:0] ag,
                         input logic rn, input logic [16:0] an);
        bus.en       = en;
        bus.req_gb   = rg;
        bus.addr_gb  = ag;
        bus.req_nes  = rn;
        bus.addr_nes = an;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string nm);
        chk({nm, " gnt_gb"},     32'(bus.gnt_gb),     32'h0);
        chk({nm, " gnt_nes"},    32'(bus.gnt_nes),    32'h0);
        chk({nm, " rvalid_gb"},  32'(bus.rvalid_gb),  32'h0);
        chk({nm, " rvalid_nes"}, 32'(bus.rvalid_nes), 32'h0);
        chk({nm, " rdata_gb"},   32'(bus.rdata_gb),   32'h0);
        chk({nm, " rdata_nes"},  32'(bus.rdata_nes),  32'h0);
        chk({nm, " rom_addr"},   32'(bus.rom_addr),   32'h0);
    endtask

    // Returns at posedge+1 of the first cycle after release (cycle 0).
    task automatic do_reset(input string nm);
        rst_n = 1'b0;
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        @(negedge clk);
        check_zero(nm);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct packed {
        logic        en;
        logic        req_gb;
        logic [17:0] addr_gb;
        logic        req_nes;
        logic [16:0] addr_nes;
        logic        gnt_gb;
        logic        gnt_nes;
        logic [17:0] rom_addr;
        logic        rv_gb;
        logic        rv_nes;
        logic [23:0] rd_gb;
        logic [23:0] rd_nes;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];

    initial begin
        bit eg, en_, erg, ern;
        int kk;

        bus_w.en = 1'b1; bus_w.req_gb = 1'b0; bus_w.addr_gb = '0;
        bus_w.req_nes = 1'b0; bus_w.addr_nes = '0;

        //         en   rg   addr_gb    rn   addr_nes   ggb  gnes rom_addr   rvg  rvn  rdata_gb      rdata_nes
        vecs[0] = '{1'b1,1'b1,18'h00010,1'b0,17'h00000, 1'b0,1'b0,18'h00000, 1'b0,1'b0,24'h000000,24'h000000};
        vecs[1] = '{1'b1,1'b1,18'h00010,1'b0,17'h00000, 1'b1,1'b0,18'h00010, 1'b0,1'b0,24'h000000,24'h000000};
        vecs[2] = '{1'b1,1'b0,18'h00000,1'b0,17'h00000, 1'b0,1'b0,18'h00010, 1'b0,1'b0,24'h000000,24'h000000};
        vecs[3] = '{1'b1,1'b0,18'h00000,1'b0,17'h00000, 1'b0,1'b0,18'h00010, 1'b0,1'b0,24'h000000,24'h000000};
        vecs[4] = '{1'b1,1'b0,18'h00000,1'b1,17'h00003, 1'b0,1'b0,18'h00010, 1'b1,1'b0,24'hA5A5B5,24'h000000};
        vecs[5] = '{1'b1,1'b0,18'h00000,1'b1,17'h00003, 1'b0,1'b1,18'h20003, 1'b0,1'b0,24'hA5A5B5,24'h000000};
        vecs[6] = '{1'b1,1'b0,18'h00000,1'b0,17'h00000, 1'b0,1'b0,18'h20003, 1'b0,1'b0,24'hA5A5B5,24'h000000};
        vecs[7] = '{1'b1,1'b0,18'h00000,1'b0,17'h00000, 1'b0,1'b0,18'h20003, 1'b0,1'b0,24'hA5A5B5,24'h000000};
        vecs[8] = '{1'b1,1'b0,18'h00000,1'b0,17'h00000, 1'b0,1'b0,18'h20003, 1'b0,1'b1,24'hA5A5B5,24'hA7A5A6};
        vecs[9] = '{1'b1,1'b0,18'h00000,1'b0,17'h00000, 1'b0,1'b0,18'h20003, 1'b0,1'b0,24'hA5A5B5,24'hA7A5A6};

        // GB alone, then NES alone
        do_reset("reset");
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].en, vecs[i].req_gb, vecs[i].addr_gb, vecs[i].req_nes, vecs[i].addr_nes);
            @(negedge clk);
            chk($sformatf("vec%0d gnt_gb", i),     32'(bus.gnt_gb),     32'(vecs[i].gnt_gb));
            chk($sformatf("vec%0d gnt_nes", i),    32'(bus.gnt_nes),    32'(vecs[i].gnt_nes));
            chk($sformatf("vec%0d rom_addr", i),   32'(bus.rom_addr),   32'(vecs[i].rom_addr));
            chk($sformatf("vec%0d rvalid_gb", i),  32'(bus.rvalid_gb),  32'(vecs[i].rv_gb));
            chk($sformatf("vec%0d rvalid_nes", i), 32'(bus.rvalid_nes), 32'(vecs[i].rv_nes));
            chk($sformatf("vec%0d rdata_gb", i),   32'(bus.rdata_gb),   32'(vecs[i].rd_gb));
            chk($sformatf("vec%0d rdata_nes", i),  32'(bus.rdata_nes),  32'(vecs[i].rd_nes));
            next_cycle();
        end

        // Both requesting for 8 cycles: GB,NES,GB,... grants, returns 3 cycles later
        do_reset("reset_b");
        drive(1'b1, 1'b1, 18'h00100, 1'b1, 17'h00005);
        for (int k = 0; k <= 12; k++) begin
            if (k == 8) drive(1'b1, 1'b0, '0, 1'b0, '0);
            @(negedge clk);
            eg  = (k >= 1 && k <= 8 && (k % 2) == 1);
            en_ = (k >= 1 && k <= 8 && (k % 2) == 0);
            kk  = k - 3;
            erg = (kk >= 1 && kk <= 8 && (kk % 2) == 1);
            ern = (kk >= 1 && kk <= 8 && (kk % 2) == 0);
            chk($sformatf("rr c%0d gnt_gb", k),  32'(bus.gnt_gb),  32'(eg));
            chk($sformatf("rr c%0d gnt_nes", k), 32'(bus.gnt_nes), 32'(en_));
            if (eg)  chk($sformatf("rr c%0d rom_addr", k), 32'(bus.rom_addr), 32'h00100);
            if (en_) chk($sformatf("rr c%0d rom_addr", k), 32'(bus.rom_addr), 32'h20005);
            chk($sformatf("rr c%0d rvalid_gb", k),  32'(bus.rvalid_gb),  32'(erg));
            chk($sformatf("rr c%0d rvalid_nes", k), 32'(bus.rvalid_nes), 32'(ern));
            chk($sformatf("rr c%0d rvalid_both", k), 32'(bus.rvalid_gb & bus.rvalid_nes), 32'h0);
            if (erg) chk($sformatf("rr c%0d rdata_gb", k),  32'(bus.rdata_gb),  32'(rom_f(18'h00100)));
            if (ern) chk($sformatf("rr c%0d rdata_nes", k), 32'(bus.rdata_nes), 32'(rom_f(18'h20005)));
            next_cycle();
        end

        // en low after a GB grant with NES pending; pointer must survive
        do_reset("reset_c");
        for (int k = 0; k <= 12; k++) begin
            drive(!(k >= 1 && k <= 5),
                  (k <= 1) || (k >= 6 && k <= 8), (k <= 1) ? 18'h00040 : 18'h00041,
                  (k <= 7), 17'h00007);
            @(negedge clk);
            chk($sformatf("en c%0d gnt_gb", k),     32'(bus.gnt_gb),     32'(k == 1 || k == 8));
            chk($sformatf("en c%0d gnt_nes", k),    32'(bus.gnt_nes),    32'(k == 7));
            chk($sformatf("en c%0d rvalid_gb", k),  32'(bus.rvalid_gb),  32'(k == 4 || k == 11));
            chk($sformatf("en c%0d rvalid_nes", k), 32'(bus.rvalid_nes), 32'(k == 10));
            if (k == 4)  chk("en rdata_gb first",  32'(bus.rdata_gb),  32'(rom_f(18'h00040)));
            if (k == 10) chk("en rdata_nes",       32'(bus.rdata_nes), 32'(rom_f(18'h20007)));
            if (k == 11) chk("en rdata_gb second", 32'(bus.rdata_gb),  32'(rom_f(18'h00041)));
            next_cycle();
        end

        // Reset pulse with three reads in flight
        do_reset("reset_d");
        drive(1'b1, 1'b1, 18'h00080, 1'b1, 17'h00009);
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            if (k == 3) chk("rst pre gnt_gb", 32'(bus.gnt_gb), 32'h1);
            if (k < 3) next_cycle();
        end
        #1 rst_n = 1'b0;
        #1 check_zero("rst async");
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        next_cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("rst post c%0d rvalid_gb", k),  32'(bus.rvalid_gb),  32'h0);
            chk($sformatf("rst post c%0d rvalid_nes", k), 32'(bus.rvalid_nes), 32'h0);
            next_cycle();
        end
        drive(1'b1, 1'b1, 18'h00080, 1'b1, 17'h00009);
        next_cycle();
        @(negedge clk);
        chk("rst first gnt_gb",  32'(bus.gnt_gb),  32'h1);
        chk("rst first gnt_nes", 32'(bus.gnt_nes), 32'h0);
        next_cycle();
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        repeat (6) next_cycle();

        // NES address wrap on both base settings
        do_reset("reset_e");
        drive(1'b1, 1'b0, '0, 1'b1, 17'h1FFFF);
        bus_w.req_nes = 1'b1; bus_w.addr_nes = 17'h1FFFF;
        for (int k = 0; k <= 5; k++) begin
            if (k == 2) begin
                drive(1'b1, 1'b0, '0, 1'b0, '0);
                bus_w.req_nes = 1'b0;
            end
            @(negedge clk);
            if (k == 1) begin
                chk("wrap gnt_nes",        32'(bus.gnt_nes),    32'h1);
                chk("wrap rom_addr base2", 32'(bus.rom_addr),   32'h3FFFF);
                chk("wrap rom_addr base3", 32'(bus_w.rom_addr), 32'h0FFFF);
            end
            chk($sformatf("wrap c%0d rvalid_nes", k), 32'(bus.rvalid_nes), 32'(k == 4));
            chk($sformatf("wrap c%0d rvalid_gb", k),  32'(bus.rvalid_gb),  32'h0);
            if (k == 4) chk("wrap rdata_nes", 32'(bus.rdata_nes), 32'(rom_f(18'h3FFFF)));
            next_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
